estagio_id_rf: RTL

- Parametrised decode/register-fetch stage for the processor datapath. Sits between IF and EX.
- Contains the write-back result mux, a multi-port register bank with write-to-read bypass, and the constant extender.
- Adds a registered ID/EX pipeline boundary with valid, stall and flush.
- Generalises the fixed 16-bit, 8-register, shared write/read-A address stage: read A and the write port now have independent selects.

---
 rtl/estagio_id_rf_if.sv | 43 ++++
 rtl/estagio_id_rf.sv | 111 +++++++++++
 2 files changed

// File: rtl/estagio_id_rf_if.sv
// Bus between the IF/WB side and the decode/register-fetch stage.
// Carries the write-back port, read selects, extender inputs and the ID/EX outputs.
interface estagio_id_rf_if #(
    parameter int LARGURA    = 16,
    parameter int NUM_REG    = 8,
    parameter int LARG_CONST = 12
);
    localparam int SEL = $clog2(NUM_REG);

    logic                  BR_Hab_Escrita;
    logic [SEL-1:0]        BR_Sel_E;
    logic [SEL-1:0]        BR_Sel_SA;
    logic [SEL-1:0]        BR_Sel_SB;
    logic [1:0]            controle;
    logic [LARGURA-1:0]    entrada_ULA;
    logic [LARGURA-1:0]    entrada_MD;
    logic [LARGURA-1:0]    entrada_PC;
    logic [2:0]            EXcontrole;
    logic [LARG_CONST-1:0] EXconstante;
    logic                  valido_in;
    logic                  stall;
    logic                  flush;
    logic [LARGURA-1:0]    A;
    logic [LARGURA-1:0]    B;
    logic [LARGURA-1:0]    constanteExtendida;
    logic                  valido_out;

    // Handshake: valido_in qualifies the decoded instruction; stall holds the ID/EX
    // register, flush squashes it (flush dominates); valido_out marks a live slot in EX.
    modport master (
        output BR_Hab_Escrita, BR_Sel_E, BR_Sel_SA, BR_Sel_SB, controle,
        output entrada_ULA, entrada_MD, entrada_PC, EXcontrole, EXconstante,
        output valido_in, stall, flush,
        input  A, B, constanteExtendida, valido_out
    );

    modport slave (
        input  BR_Hab_Escrita, BR_Sel_E, BR_Sel_SA, BR_Sel_SB, controle,
        input  entrada_ULA, entrada_MD, entrada_PC, EXcontrole, EXconstante,
        input  valido_in, stall, flush,
        output A, B, constanteExtendida, valido_out
    );
endinterface

// File: rtl/estagio_id_rf.sv
// Decode/register-fetch stage: write-back mux, bypassed register bank, constant
// extender and a registered ID/EX boundary with valid, stall and flush.
module estagio_id_rf #(
    parameter int LARGURA    = 16,
    parameter int NUM_REG    = 8,
    parameter int LARG_CONST = 12,
    parameter int R0_ZERO    = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    estagio_id_rf_if.slave       bus
);
    localparam int SEL = $clog2(NUM_REG);

    logic [LARGURA-1:0] regs_q [NUM_REG];
    logic [LARGURA-1:0] regs_d [NUM_REG];
    logic [LARGURA-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic               v_q, v_d;

    logic [LARGURA-1:0] saida_mux;
    logic [LARGURA-1:0] rd_a, rd_b, ext;
    logic               wr_en;
    logic [7:0]         k8;
    logic [3:0]         k4;

    always_comb begin
        saida_mux = '0;
        case (bus.controle)
            2'b00:   saida_mux = bus.entrada_ULA;
            2'b01:   saida_mux = bus.entrada_MD;
            2'b10:   saida_mux = bus.entrada_PC;
            default: saida_mux = '0;
        endcase
    end

    // A write to the hard-wired zero register is dropped before it reaches the bank or the bypass.
    assign wr_en = bus.BR_Hab_Escrita && !((R0_ZERO != 0) && (bus.BR_Sel_E == '0));

    always_comb begin
        rd_a = regs_q[bus.BR_Sel_SA];
        if (wr_en && (bus.BR_Sel_E == bus.BR_Sel_SA)) rd_a = saida_mux;
        if ((R0_ZERO != 0) && (bus.BR_Sel_SA == '0)) rd_a = '0;
    end

    always_comb begin
        rd_b = regs_q[bus.BR_Sel_SB];
        if (wr_en && (bus.BR_Sel_E == bus.BR_Sel_SB)) rd_b = saida_mux;
        if ((R0_ZERO != 0) && (bus.BR_Sel_SB == '0)) rd_b = '0;
    end

    assign k8 = bus.EXconstante[7:0];
    assign k4 = bus.EXconstante[3:0];

    always_comb begin
        ext = '0;
        case (bus.EXcontrole)
            3'b000:  ext = LARGURA'(bus.EXconstante);
            3'b001:  ext = LARGURA'($signed(bus.EXconstante));
            3'b010:  ext = LARGURA'($signed(k8));
            3'b011:  ext = LARGURA'(k8);
            3'b100:  ext = LARGURA'(k8) << (LARGURA - 8);
            3'b101:  ext = LARGURA'($signed(k4));
            default: ext = '0;
        endcase
    end

    always_comb begin
        regs_d = regs_q;
        if (wr_en) regs_d[bus.BR_Sel_E] = saida_mux;
    end

    // Write-back belongs to a later stage, so only the ID/EX slot obeys stall/flush.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        c_d = c_q;
        v_d = v_q;
        if (bus.flush) begin
            a_d = '0;
            b_d = '0;
            c_d = '0;
            v_d = 1'b0;
        end else if (!bus.stall) begin
            a_d = rd_a;
            b_d = rd_b;
            c_d = ext;
            v_d = bus.valido_in;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            regs_q <= '{default: '0};
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= '0;
            v_q    <= 1'b0;
        end else begin
            regs_q <= regs_d;
            a_q    <= a_d;
            b_q    <= b_d;
            c_q    <= c_d;
            v_q    <= v_d;
        end
    end

    assign bus.A                  = a_q;
    assign bus.B                  = b_q;
    assign bus.constanteExtendida = c_q;
    assign bus.valido_out         = v_q;
endmodule
